// File: rtl/wave_mac_seq_if.sv
// Bundle of tile-input, MAC-lane and result handshake signals for the Wave MAC sequencer.
// The slave modport is the sequencer's view; master is the tile source / MAC / result sink.
interface wave_mac_seq_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int VEC_LENGTH   = 16,
   parameter int RESULT_WIDTH = 3 * DATA_WIDTH,
   parameter int ACC_WIDTH    = DATA_WIDTH + 16
);
   logic                                  in_valid;
   logic                                  in_ready;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_act;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_w;
   logic                                  in_first;
   logic                                  in_last;
   logic                                  skip_zero_cols;
   logic                                  mac_en;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mac_act;
   logic [VEC_LENGTH-1:0]                 mac_sign;
   logic [VEC_LENGTH-1:0]                 mac_w_bit;
   logic [2:0]                            mac_column_idx;
   logic signed [RESULT_WIDTH-1:0]        mac_result;
   logic                                  out_valid;
   logic                                  out_ready;
   logic signed [ACC_WIDTH-1:0]           out_data;
   logic                                  busy;

   modport master (
      output in_valid, in_act, in_w, in_first, in_last, skip_zero_cols, mac_result, out_ready,
      input  in_ready, mac_en, mac_act, mac_sign, mac_w_bit, mac_column_idx, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_act, in_w, in_first, in_last, skip_zero_cols, mac_result, out_ready,
      output in_ready, mac_en, mac_act, mac_sign, mac_w_bit, mac_column_idx, out_valid, out_data, busy
   );
endinterface

// File: rtl/wave_mac_seq_ctrl.sv
// Sequencer/accumulator for the bit-serial Wave MAC: issues weight magnitude columns MSB-first,
// accumulates the MAC's shifted partial sums across columns and chained tiles.
module wave_mac_seq_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int VEC_LENGTH   = 16,
   parameter int NUM_COLS     = DATA_WIDTH - 1,
   parameter int RESULT_WIDTH = 3 * DATA_WIDTH,
   parameter int ACC_WIDTH    = DATA_WIDTH + 16
) (
   input logic           clk,
   input logic           reset,
   wave_mac_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, OUTPUT} state_t;

   state_t                                state, state_nxt;
   logic                                  accept;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_p0;
   logic [VEC_LENGTH-1:0]                 sign_p0;
   logic [VEC_LENGTH-1:0][NUM_COLS-1:0]   mag_p0;
   logic                                  last_p0;
   logic [NUM_COLS-1:0]                   mask_p0, mask_in, mask_nxt;
   logic [2:0]                            col_sel;
   logic                                  vld_p1;
   logic signed [ACC_WIDTH-1:0]           acc;

   function automatic logic signed [ACC_WIDTH-1:0] sext_result(
      input logic signed [RESULT_WIDTH-1:0] v
   );
      return ACC_WIDTH'(v);
   endfunction

   // Column mask captured at accept: with skipping, only columns some lane has a 1 in.
   always_comb begin
      mask_in = '1;
      if (bus.skip_zero_cols) begin
         mask_in = '0;
         for (int j = 0; j < VEC_LENGTH; j++) mask_in = mask_in | bus.in_w[j][NUM_COLS-1:0];
      end
   end

   always_comb begin
      col_sel = '0;
      for (int c = 0; c < NUM_COLS; c++) if (mask_p0[c]) col_sel = 3'(c);
   end

   assign mask_nxt = mask_p0 & ~(NUM_COLS'(1) << col_sel);

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      bus.mac_en = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = (mask_in != '0) ? COMPUTE : DRAIN;
            end
         end
         COMPUTE: begin
            bus.mac_en = 1'b1;
            if (mask_nxt == '0) state_nxt = DRAIN;
         end
         DRAIN:   state_nxt = last_p0 ? OUTPUT : IDLE;
         OUTPUT:  if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mac_w_bit = '0;
      for (int j = 0; j < VEC_LENGTH; j++) bus.mac_w_bit[j] = bus.mac_en & mag_p0[j][col_sel];
   end

   assign bus.mac_column_idx = bus.mac_en ? col_sel : 3'd0;
   assign bus.mac_act        = act_p0;
   assign bus.mac_sign       = sign_p0;
   assign bus.in_ready       = (state == IDLE);
   assign bus.busy           = (state != IDLE);
   assign bus.out_valid      = (state == OUTPUT);
   assign bus.out_data       = acc;

   // Stage p0: tile capture and column walk; stage p1: MAC result arrives one cycle after issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         vld_p1  <= 1'b0;
         mask_p0 <= '0;
         last_p0 <= 1'b0;
         act_p0  <= '0;
         sign_p0 <= '0;
         acc     <= '0;
      end else begin
         state  <= state_nxt;
         vld_p1 <= bus.mac_en;
         if (accept) begin
            act_p0  <= bus.in_act;
            mask_p0 <= mask_in;
            last_p0 <= bus.in_last;
            for (int j = 0; j < VEC_LENGTH; j++) sign_p0[j] <= bus.in_w[j][DATA_WIDTH-1];
         end else if (bus.mac_en) begin
            mask_p0 <= mask_nxt;
         end
         if (accept && bus.in_first) acc <= '0;
         else if (vld_p1)            acc <= acc + sext_result(bus.mac_result);
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         for (int j = 0; j < VEC_LENGTH; j++) mag_p0[j] <= bus.in_w[j][NUM_COLS-1:0];
   end
endmodule

// File: tb/tb_wave_mac_seq_ctrl.sv
// Directed table-driven bench for wave_mac_seq_ctrl with a behavioral bit-serial MAC lane model.
module tb_wave_mac_seq_ctrl;
   localparam int DW = 8;
   localparam int VL = 16;
   localparam int NC = DW - 1;
   localparam int RW = 3 * DW;
   localparam int AW = DW + 16;

   typedef struct {
      logic [DW-1:0] act;
      logic [DW-1:0] w;
      logic [DW-1:0] act0;
      logic [DW-1:0] w0;
      bit            first;
      bit            last;
      bit            skip;
      int            k;
      longint        data;
      int            hold;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t tbl[8];
   vec_t rv;

   always #5 clk = ~clk;

   wave_mac_seq_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .RESULT_WIDTH(RW), .ACC_WIDTH(AW)) bus ();

   wave_mac_seq_ctrl #(
      .DATA_WIDTH(DW), .VEC_LENGTH(VL), .NUM_COLS(NC), .RESULT_WIDTH(RW), .ACC_WIDTH(AW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   // MAC lane model: signed-magnitude product of the issued bit, shifted by column, registered.
   always @(posedge clk) begin : mac_model
      longint s;
      longint a;
      s = 0;
      if (bus.mac_en) begin
         for (int j = 0; j < VL; j++) begin
            a = longint'($signed(bus.mac_act[j]));
            if (bus.mac_w_bit[j]) s = bus.mac_sign[j] ? s - a : s + a;
         end
         s = s <<< bus.mac_column_idx;
      end
      bus.mac_result <= RW'(s);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_tile(input vec_t v, input string tag);
      logic [NC-1:0] mag[VL];
      logic [NC-1:0] mask;
      logic [VL-1:0] ewb;
      logic [VL-1:0] esign;
      int            issues;
      int            endc;
      int            ecol;
      bit            done;
      mask = '0;
      for (int j = 0; j < VL; j++) begin
         mag[j]   = (j == 0) ? v.w0[NC-1:0] : v.w[NC-1:0];
         esign[j] = (j == 0) ? v.w0[DW-1] : v.w[DW-1];
         mask     = mask | mag[j];
         bus.in_act[j] = (j == 0) ? v.act0 : v.act;
         bus.in_w[j]   = (j == 0) ? v.w0 : v.w;
      end
      if (!v.skip) mask = '1;
      bus.in_first       = v.first;
      bus.in_last        = v.last;
      bus.skip_zero_cols = v.skip;
      chk({tag, " in_ready_before_accept"}, bus.in_ready, 1);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk({tag, " mac_act0"}, bus.mac_act[0], v.act0);
      chk({tag, " mac_act1"}, bus.mac_act[1], v.act);
      chk({tag, " mac_sign"}, bus.mac_sign, esign);
      issues = 0;
      endc   = -1;
      done   = 1'b0;
      for (int cyc = 1; cyc <= 12 && !done; cyc++) begin
         if (bus.mac_en) begin
            ecol = -1;
            for (int c = NC - 1; c >= 0; c--) if (mask[c] && ecol < 0) ecol = c;
            chk({tag, " issue_expected"}, (ecol >= 0), 1);
            if (ecol >= 0) begin
               for (int j = 0; j < VL; j++) ewb[j] = mag[j][ecol];
               chk({tag, " column_idx"}, bus.mac_column_idx, ecol);
               chk({tag, " w_bit"}, bus.mac_w_bit, ewb);
               mask[ecol] = 1'b0;
            end
            issues++;
         end else begin
            chk({tag, " idle_w_bit_idx"}, {bus.mac_w_bit, bus.mac_column_idx}, 0);
         end
         if (v.last ? bus.out_valid : bus.in_ready) begin
            endc = cyc;
            done = 1'b1;
         end else begin
            tick();
         end
      end
      chk({tag, " issue_count"}, issues, v.k);
      chk({tag, " finish_cycle"}, endc, v.k + 2);
      if (v.last && done) begin
         for (int h = 0; h < v.hold; h++) begin
            chk({tag, " hold_out_valid"}, bus.out_valid, 1);
            chk({tag, " hold_out_data"}, bus.out_data, AW'(v.data));
            chk({tag, " hold_in_ready"}, bus.in_ready, 0);
            tick();
         end
         chk({tag, " out_data"}, bus.out_data, AW'(v.data));
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
         chk({tag, " out_valid_after_xfer"}, bus.out_valid, 0);
         chk({tag, " in_ready_after_xfer"}, bus.in_ready, 1);
      end
   endtask

   initial begin
      tbl[0] = '{8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1, 1, 16, 0};
      tbl[1] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b1, 1'b0, 7, 258064, 0};
      tbl[2] = '{8'h05, 8'h00, 8'h80, 8'hFF, 1'b1, 1'b1, 1'b1, 7, 16256, 0};
      tbl[3] = '{8'h03, 8'h00, 8'h03, 8'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0};
      tbl[4] = '{8'h03, 8'h00, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0, 7, 0, 0};
      tbl[5] = '{8'h09, 8'h80, 8'h09, 8'h80, 1'b1, 1'b1, 1'b0, 7, 0, 0};
      tbl[6] = '{8'h02, 8'h03, 8'h02, 8'h03, 1'b1, 1'b0, 1'b1, 2, 0, 0};
      tbl[7] = '{8'h01, 8'h81, 8'h01, 8'h81, 1'b0, 1'b1, 1'b1, 1, 80, 5};

      reset              = 1'b1;
      bus.in_valid       = 1'b0;
      bus.in_act         = '0;
      bus.in_w           = '0;
      bus.in_first       = 1'b0;
      bus.in_last        = 1'b0;
      bus.skip_zero_cols = 1'b0;
      bus.out_ready      = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst in_ready", bus.in_ready, 1);
      chk("rst busy", bus.busy, 0);
      chk("rst mac_en", bus.mac_en, 0);
      chk("rst mac_w_bit", bus.mac_w_bit, 0);
      chk("rst mac_column_idx", bus.mac_column_idx, 0);
      chk("rst mac_act", bus.mac_act[0], 0);
      chk("rst mac_sign", bus.mac_sign, 0);
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst out_data", bus.out_data, 0);

      for (int i = 0; i < 8; i++) run_tile(tbl[i], $sformatf("vec%0d", i));

      // Reset in the third COMPUTE cycle of a full-column tile, then a non-first tile.
      for (int j = 0; j < VL; j++) begin
         bus.in_act[j] = 8'h01;
         bus.in_w[j]   = 8'h7F;
      end
      bus.in_first       = 1'b1;
      bus.in_last        = 1'b1;
      bus.skip_zero_cols = 1'b0;
      bus.in_valid       = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("rstmid compute3 mac_en", bus.mac_en, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstmid in_ready", bus.in_ready, 1);
      chk("rstmid mac_en", bus.mac_en, 0);
      chk("rstmid out_valid", bus.out_valid, 0);
      chk("rstmid busy", bus.busy, 0);
      chk("rstmid out_data", bus.out_data, 0);
      rv = '{8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 1, 16, 0};
      run_tile(rv, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
